// File: rtl/fifo_pixel_unpacker.sv
// Display FIFO read-side unpacker: prefetches 32-bit words into a two-word
// buffer and streams RGB565 pixels with SOF/EOL markers and an underrun count.
module fifo_pixel_unpacker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int LSB_FIRST = 1,
  parameter int UCNT_W    = 16
) (
  input  logic              clk,
  input  logic              tb_rst,
  input  logic              enable,
  input  logic [31:0]       fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_active,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic          SWAP   = (LSB_FIRST == 0);

  logic [31:0]       w0;
  logic [31:0]       w1;
  logic [1:0]        occ;
  logic              inflight;
  logic              half;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              frame_q;
  logic [UCNT_W-1:0] ucnt;

  logic [1:0] pend;
  logic       push;
  logic       pop;
  logic       xfer;
  logic       x_end;
  logic       y_end;
  logic       at_origin;
  logic       starve;

  // occ + inflight never exceeds 2, so two bits suffice
  assign pend = occ + {1'b0, inflight};

  assign fifo_rd_en = ~tb_rst & enable & ~fifo_rd_empty
                    & (pend < 2'd2);

  assign pix_valid = (occ != 2'd0);
  assign xfer      = pix_valid & pix_ready;
  assign push      = inflight;
  assign pop       = xfer & half;

  assign x_end     = (x == X_LAST);
  assign y_end     = (y == Y_LAST);
  assign at_origin = (x == '0) & (y == '0);
  assign starve    = frame_q & pix_ready & ~pix_valid;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      w0  <= '0;
      w1  <= '0;
      occ <= 2'd0;
    end else begin
      unique case (1'b1)
        push & pop: begin
          if (occ == 2'd2) begin
            w0 <= w1;
            w1 <= fifo_rd_data;
          end else begin
            w0 <= fifo_rd_data;
          end
        end
        push & ~pop: begin
          if (occ == 2'd0) w0 <= fifo_rd_data;
          else             w1 <= fifo_rd_data;
        end
        ~push & pop: begin
          w0 <= w1;
        end
        default: begin
        end
      endcase
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      half <= 1'b0;
    end else if (xfer) begin
      half <= ~half;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      x <= '0;
      y <= '0;
    end else if (xfer) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      frame_q <= 1'b0;
    end else if (xfer) begin
      if (x_end & y_end) frame_q <= 1'b0;
      else if (at_origin) frame_q <= 1'b1;
    end
  end

  // saturates at all-ones; only reset clears it
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      ucnt <= '0;
    end else if (starve & ~&ucnt) begin
      ucnt <= ucnt + UCNT_W'(1);
    end
  end

  always_comb begin
    pix_data = 16'h0000;
    if (pix_valid) begin
      pix_data = (half ^ SWAP) ? w0[31:16] : w0[15:0];
    end
  end

  assign pix_sof      = pix_valid & at_origin;
  assign pix_eol      = pix_valid & x_end;
  assign frame_active = frame_q;
  assign underrun_cnt = ucnt;

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Scoreboard bench for fifo_pixel_unpacker: small FIFO model on the read
// side, expected pixels queued at push time and checked on each transfer.
module tb_fifo_pixel_unpacker;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FR = H * V;
  localparam int UW = 4;

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    logic        sof;
    logic        eol;
    logic        fa;
  } exp_t;

  logic          clk = 1'b0;
  logic          tb_rst = 1'b1;
  logic          enable = 1'b0;
  logic          pix_ready = 1'b0;
  logic [31:0]   fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_eol;
  logic          frame_active;
  logic [UW-1:0] underrun_cnt;

  logic          rd_en_b;
  logic [15:0]   pix_data_b;
  logic          pix_valid_b;
  logic          pix_sof_b;
  logic          pix_eol_b;
  logic          frame_active_b;
  logic [UW-1:0] underrun_cnt_b;

  logic [31:0] mem [256];
  logic [7:0]  wp = '0;
  logic [7:0]  rp = '0;
  int          rd_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pos = 0;
  exp_t        exp_q[$];
  exp_t        m_e;

  fifo_pixel_unpacker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LSB_FIRST(1), .UCNT_W(UW)
  ) dut (
    .clk(clk), .tb_rst(tb_rst), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_active(frame_active), .underrun_cnt(underrun_cnt)
  );

  fifo_pixel_unpacker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LSB_FIRST(0), .UCNT_W(UW)
  ) dut_msb (
    .clk(clk), .tb_rst(tb_rst), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(rd_en_b), .pix_data(pix_data_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready),
    .pix_sof(pix_sof_b), .pix_eol(pix_eol_b),
    .frame_active(frame_active_b), .underrun_cnt(underrun_cnt_b)
  );

  always #5 clk = ~clk;

  assign fifo_rd_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp];
      rp <= rp + 8'd1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    mem[wp] = w;
    wp = wp + 8'd1;
    for (int k = 0; k < 2; k++) begin
      e.d   = (k == 0) ? w[15:0]  : w[31:16];
      e.a   = (k == 0) ? w[31:16] : w[15:0];
      e.sof = (pos == 0);
      e.eol = ((pos % H) == H - 1);
      e.fa  = (pos != 0);
      exp_q.push_back(e);
      pos = (pos + 1) % FR;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!tb_rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_pix", 32'(pix_valid), 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("pix_data", 32'(pix_data), 32'(m_e.d));
        chk("pix_data_msb", 32'(pix_data_b), 32'(m_e.a));
        chk("pix_sof", 32'(pix_sof), 32'(m_e.sof));
        chk("pix_eol", 32'(pix_eol), 32'(m_e.eol));
        chk("frame_act", 32'(frame_active), 32'(m_e.fa));
      end
    end
  end

  initial begin
    int cnt;
    int r0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_sof", 32'(pix_sof), 32'd0);
    chk("rst_eol", 32'(pix_eol), 32'd0);
    chk("rst_rden", 32'(fifo_rd_en), 32'd0);
    chk("rst_fa", 32'(frame_active), 32'd0);
    chk("rst_ucnt", 32'(underrun_cnt), 32'd0);

    push_word(32'h0002_0001);
    push_word(32'h0004_0003);
    push_word(32'h0006_0005);
    push_word(32'h0008_0007);
    enable = 1'b1;
    pix_ready = 1'b1;
    chk("rden_in_rst", 32'(fifo_rd_en), 32'd0);
    tb_rst = 1'b0;
    #1;
    chk("rden_first", 32'(fifo_rd_en), 32'd1);

    for (int i = 0; i < 20 && !pix_valid; i++) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(pix_valid);
      @(negedge clk);
    end
    chk("burst_len", 32'(cnt), 32'd8);
    wait_drain("drain_a");
    chk("fa_end", 32'(frame_active), 32'd0);
    chk("ucnt_stream", 32'(underrun_cnt), 32'd0);

    pix_ready = 1'b0;
    r0 = rd_cnt;
    push_word(32'hB002_A001);
    push_word(32'hB004_A003);
    push_word(32'hB006_A005);
    push_word(32'hB008_A007);
    repeat (8) @(posedge clk);
    #1;
    chk("bp_reads", 32'(rd_cnt - r0), 32'd2);
    chk("bp_rden", 32'(fifo_rd_en), 32'd0);
    chk("bp_valid", 32'(pix_valid), 32'd1);
    chk("bp_head", 32'(pix_data), 32'h0000_A001);
    pix_ready = 1'b1;
    wait_drain("drain_bp");
    chk("bp_total", 32'(rd_cnt - r0), 32'd4);
    chk("ucnt_bp", 32'(underrun_cnt), 32'd0);

    push_word(32'hC002_C001);
    wait_drain("drain_u");
    pix_ready = 1'b0;
    chk("ucnt_pre", 32'(underrun_cnt), 32'd0);
    chk("fa_mid", 32'(frame_active), 32'd1);
    pix_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pix_ready = 1'b0;
    chk("ucnt_5", 32'(underrun_cnt), 32'd5);
    pix_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("ucnt_sat", 32'(underrun_cnt), 32'd15);
    push_word(32'hD002_D001);
    push_word(32'hD004_D003);
    push_word(32'hD006_D005);
    wait_drain("drain_refill");
    chk("fa_refill", 32'(frame_active), 32'd0);

    push_word(32'hE002_E001);
    push_word(32'hE004_E003);
    for (int i = 0; i < 40 && exp_q.size() >= 4; i++) begin
      @(posedge clk);
      #1;
    end
    tb_rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(pix_valid), 32'd0);
    chk("mrst_data", 32'(pix_data), 32'd0);
    chk("mrst_data_msb", 32'(pix_data_b), 32'd0);
    chk("mrst_eol", 32'(pix_eol), 32'd0);
    chk("mrst_fa", 32'(frame_active), 32'd0);
    chk("mrst_rden", 32'(fifo_rd_en), 32'd0);
    chk("mrst_ucnt", 32'(underrun_cnt), 32'd0);
    exp_q.delete();
    wp = rp;
    pos = 0;
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    push_word(32'h00AA_00BB);
    for (int i = 0; i < 20 && !pix_valid; i++) @(negedge clk);
    chk("post_rst_sof", 32'(pix_sof), 32'd1);
    chk("post_rst_pix", 32'(pix_data), 32'h0000_00BB);
    wait_drain("drain_post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
